video_timing_recover: RTL and testbench

- Sink-side counterpart of the video timing generator.
- Consumes a raw single-pulse hsync/vsync plus de stream (generator-style timing) and recovers per-pixel x/y coordinates.
- Measures active width/height and line period, and reports lock once frame geometry is stable.
- Sits ahead of any video consumer (scaler, capture, OSD) that needs coordinates without sharing the generator's counters.

---
 rtl/video_timing_recover.sv | 169 ++++++++++++++++
 tb/tb_video_timing_recover.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_recover.sv
// Sink-side timing recovery: rebuilds x/y coordinates from a hsync/vsync/de
// stream, measures frame geometry and reports lock once it is stable.
module video_timing_recover #(
    parameter int COUNT_WIDTH = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vid_hsync,
    input  logic                   vid_vsync,
    input  logic                   vid_de,
    output logic                   out_de,
    output logic [COUNT_WIDTH-1:0] out_x,
    output logic [COUNT_WIDTH-1:0] out_y,
    output logic                   frame_start,
    output logic [COUNT_WIDTH-1:0] active_width,
    output logic [COUNT_WIDTH-1:0] active_height,
    output logic [COUNT_WIDTH-1:0] h_total,
    output logic                   locked,
    output logic                   error
);

    localparam logic [COUNT_WIDTH-1:0] CMAX = '1;
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t state, state_n;

    logic [COUNT_WIDTH-1:0] pix_cnt, line_cnt, first_w, hcnt;
    logic [COUNT_WIDTH-1:0] cand_w, cand_h, cand_w_n, cand_h_n;
    logic [3:0] match_cnt, match_cnt_n;
    logic de_prev, frame_bad, sat_line, hs_valid, vs_seen;

    logic [COUNT_WIDTH-1:0] pix_next, line_next, line_w, frame_w;
    logic pix_sat, line_end, line_sat, w_bad, bad_now;
    logic consistent, hit, lock_loss, sat_err;

    always_comb begin
        pix_sat   = vid_de && (pix_cnt == CMAX);
        pix_next  = (vid_de && !pix_sat) ? pix_cnt + 1'b1 : pix_cnt;
        // vsync during de closes the line with this cycle's pixel included
        line_end  = (de_prev && !vid_de) || (vid_vsync && vid_de);
        line_w    = pix_next;
        line_sat  = line_end && (line_cnt == CMAX);
        line_next = (line_end && !line_sat) ? line_cnt + 1'b1 : line_cnt;
        w_bad     = line_end && (line_cnt != '0) && (line_w != first_w);
        frame_w   = (line_cnt == '0) ? line_w : first_w;
        bad_now   = frame_bad || pix_sat || line_sat || w_bad
                    || (vid_vsync && vid_de);
        consistent = vid_vsync && !bad_now && (line_next != '0);
        hit       = consistent && (frame_w == cand_w)
                    && (line_next == cand_h);
        sat_err   = pix_sat && !sat_line;
    end

    always_comb begin
        state_n     = state;
        cand_w_n    = cand_w;
        cand_h_n    = cand_h;
        match_cnt_n = match_cnt;
        lock_loss   = 1'b0;
        if (vid_vsync) begin
            unique case (state)
                IDLE: state_n = ACQUIRE;
                ACQUIRE: begin
                    if (hit) begin
                        match_cnt_n = match_cnt + 4'd1;
                    end else if (consistent) begin
                        cand_w_n    = frame_w;
                        cand_h_n    = line_next;
                        match_cnt_n = 4'd1;
                    end else begin
                        match_cnt_n = 4'd0;
                    end
                    if (match_cnt_n >= LOCK_N) state_n = LOCKED;
                end
                LOCKED: begin
                    if (!hit) begin
                        lock_loss = 1'b1;
                        state_n   = ACQUIRE;
                        if (consistent) begin
                            cand_w_n    = frame_w;
                            cand_h_n    = line_next;
                            match_cnt_n = 4'd1;
                        end else begin
                            match_cnt_n = 4'd0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cand_w    <= '0;
            cand_h    <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
        end else begin
            state     <= state_n;
            cand_w    <= cand_w_n;
            cand_h    <= cand_h_n;
            match_cnt <= match_cnt_n;
            locked    <= (state_n == LOCKED);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            de_prev       <= 1'b0;
            pix_cnt       <= '0;
            line_cnt      <= '0;
            first_w       <= '0;
            frame_bad     <= 1'b0;
            sat_line      <= 1'b0;
            out_de        <= 1'b0;
            out_x         <= '0;
            out_y         <= '0;
            frame_start   <= 1'b0;
            active_width  <= '0;
            active_height <= '0;
            error         <= 1'b0;
        end else begin
            de_prev     <= vid_de && !vid_vsync;
            out_de      <= vid_de;
            out_x       <= vid_de ? pix_cnt : '0;
            out_y       <= vid_de ? line_cnt : '0;
            frame_start <= vid_vsync;
            error       <= sat_err || (vid_vsync && vid_de) || lock_loss;
            sat_line    <= line_end ? 1'b0 : (sat_line || pix_sat);
            pix_cnt     <= (line_end || vid_vsync) ? '0 : pix_next;
            line_cnt    <= vid_vsync ? '0 : line_next;
            frame_bad   <= vid_vsync ? 1'b0 : bad_now;
            if (line_end && (line_cnt == '0)) first_w <= line_w;
            // the partial frame seen from IDLE is never measured
            if (consistent && (state != IDLE)) begin
                active_width  <= frame_w;
                active_height <= line_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt     <= '0;
            hs_valid <= 1'b0;
            vs_seen  <= 1'b0;
            h_total  <= '0;
        end else if (vid_hsync) begin
            if (hs_valid && !vs_seen && !vid_vsync && (hcnt != CMAX))
                h_total <= hcnt + 1'b1;
            hcnt     <= '0;
            hs_valid <= 1'b1;
            vs_seen  <= 1'b0;
        end else begin
            if (hcnt != CMAX) hcnt <= hcnt + 1'b1;
            if (vid_vsync) vs_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_timing_recover.sv
// Bench for video_timing_recover: random geometries driven through a
// frame-level reference model, checked every cycle.
module tb_video_timing_recover;

    localparam int CW = 10;
    localparam int LF = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset, vid_hsync, vid_vsync, vid_de;
    logic out_de, frame_start, locked, error;
    logic [CW-1:0] out_x, out_y, active_width, active_height, h_total;

    video_timing_recover #(.COUNT_WIDTH(CW), .LOCK_FRAMES(LF)) dut (
        .clk(clk), .reset(reset),
        .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de),
        .out_de(out_de), .out_x(out_x), .out_y(out_y),
        .frame_start(frame_start),
        .active_width(active_width), .active_height(active_height),
        .h_total(h_total), .locked(locked), .error(error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int widths[$];
    int run_len, cyc, prev_hs;
    bit open_line, viol, have_prev, vs_since;
    bit m_idle, m_locked;
    int m_aw, m_ah, m_ht, m_cw, m_ch, m_mc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        widths.delete();
        run_len = 0; cyc = 0; prev_hs = 0;
        open_line = 0; viol = 0; have_prev = 0; vs_since = 0;
        m_idle = 1; m_locked = 0;
        m_aw = 0; m_ah = 0; m_ht = 0; m_cw = 0; m_ch = 0; m_mc = 0;
    endtask

    task automatic end_frame(inout bit err);
        int fw, fh;
        bit ok;
        fh = widths.size();
        fw = (fh > 0) ? widths[0] : 0;
        ok = !viol && (fh > 0);
        foreach (widths[i]) if (widths[i] != fw || widths[i] > CMAX) ok = 0;
        if (m_idle) begin
            m_idle = 0;
        end else begin
            if (ok) begin m_aw = fw; m_ah = fh; end
            if (m_locked) begin
                if (!(ok && fw == m_cw && fh == m_ch)) begin
                    m_locked = 0;
                    err = 1;
                    if (ok) begin m_cw = fw; m_ch = fh; m_mc = 1; end
                    else m_mc = 0;
                end
            end else begin
                if (ok && fw == m_cw && fh == m_ch) m_mc++;
                else if (ok) begin m_cw = fw; m_ch = fh; m_mc = 1; end
                else m_mc = 0;
                if (m_mc >= LF) m_locked = 1;
            end
        end
        widths.delete();
        viol = 0; run_len = 0; open_line = 0;
    endtask

    task automatic step(input bit hs, input bit vs, input bit de);
        bit err;
        int ex, ey;
        err = 0; ex = 0; ey = 0;
        cyc++;
        if (de) begin
            run_len++;
            if (run_len == CMAX + 1) err = 1;
            ex = (run_len - 1 > CMAX) ? CMAX : run_len - 1;
            ey = (widths.size() > CMAX) ? CMAX : widths.size();
            open_line = 1;
        end else if (open_line) begin
            widths.push_back(run_len);
            run_len = 0;
            open_line = 0;
        end
        if (vs) begin
            if (de) begin
                widths.push_back(run_len);
                viol = 1;
                err = 1;
            end
            end_frame(err);
            vs_since = 1;
        end
        if (hs) begin
            if (have_prev && !vs_since && cyc - prev_hs <= CMAX)
                m_ht = cyc - prev_hs;
            prev_hs = cyc;
            have_prev = 1;
            vs_since = 0;
        end
        vid_hsync = hs; vid_vsync = vs; vid_de = de;
        @(posedge clk);
        #1;
        chk("out_de", out_de, de);
        if (de) begin
            chk("out_x", out_x, ex);
            chk("out_y", out_y, ey);
        end
        chk("frame_start", frame_start, vs);
        chk("error", error, err);
        chk("locked", locked, m_locked);
        chk("active_width", active_width, m_aw);
        chk("active_height", active_height, m_ah);
        chk("h_total", h_total, m_ht);
    endtask

    task automatic do_reset();
        reset = 1; vid_hsync = 0; vid_vsync = 0; vid_de = 0;
        @(posedge clk);
        #1;
        chk("rst_out_de", out_de, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_width", active_width, 0);
        chk("rst_height", active_height, 0);
        chk("rst_h_total", h_total, 0);
        chk("rst_locked", locked, 0);
        chk("rst_error", error, 0);
        reset = 0;
        model_reset();
    endtask

    // h active lines, 3 blank lines, vsync in place of hsync on blank line 2;
    // vod puts the vsync on the last de cycle of the last active line
    task automatic send_frame(input int w, input int h, input int sl,
                              input int sw, input bit vod);
        int per, hp, lw;
        bit de, vs, hs;
        per = w + 6;
        hp = w + 2;
        for (int l = 0; l < h + 3; l++) begin
            lw = (l == sl) ? sw : ((l < h) ? w : 0);
            for (int c = 0; c < per; c++) begin
                de = (c < lw);
                if (vod) vs = (l == h - 1) && (c == lw - 1);
                else vs = (l == h + 1) && (c == hp);
                hs = (c == hp) && !vs;
                step(hs, vs, de);
            end
        end
    endtask

    int w1, h1, w2, h2;

    initial begin
        reset = 1; vid_hsync = 0; vid_vsync = 0; vid_de = 0;
        model_reset();
        w1 = $urandom_range(8, 40);
        h1 = $urandom_range(2, 8);
        w2 = w1 + $urandom_range(1, 6);
        h2 = $urandom_range(2, 8);

        do_reset();

        // acquire: locked after the third vsync
        send_frame(w1, h1, -1, 0, 0);
        send_frame(w1, h1, -1, 0, 0);
        chk("not_yet_locked", locked, 0);
        send_frame(w1, h1, -1, 0, 0);
        chk("locked_after_3", locked, 1);
        chk("width", active_width, w1);
        chk("height", active_height, h1);
        chk("h_total_val", h_total, w1 + 6);

        // one short line drops lock, two clean frames restore it
        send_frame(w1, h1, $urandom_range(0, h1 - 1), w1 - 1, 0);
        chk("short_unlocked", locked, 0);
        send_frame(w1, h1, -1, 0, 0);
        send_frame(w1, h1, -1, 0, 0);
        chk("short_relock", locked, 1);

        // geometry change
        send_frame(w2, h2, -1, 0, 0);
        send_frame(w2, h2, -1, 0, 0);
        send_frame(w2, h2, -1, 0, 0);
        chk("geom2_locked", locked, 1);
        chk("geom2_width", active_width, w2);

        // vsync during de, from LOCKED and then from ACQUIRE
        send_frame(w2, h2, -1, 0, 1);
        send_frame(w2, h2, -1, 0, 1);
        chk("vod_unlocked", locked, 0);
        send_frame(w2, h2, -1, 0, 0);
        send_frame(w2, h2, -1, 0, 0);
        chk("vod_relock", locked, 1);

        // pixel counter saturation on a 1100-cycle line
        send_frame(1100, 1, -1, 0, 0);
        chk("sat_unlocked", locked, 0);
        send_frame(w1, h1, -1, 0, 0);
        send_frame(w1, h1, -1, 0, 0);
        chk("sat_relock", locked, 1);

        // reset mid-frame while LOCKED
        for (int c = 0; c < 2 * (w1 + 6); c++)
            step(c % (w1 + 6) == w1 + 2, 1'b0, c % (w1 + 6) < w1);
        do_reset();
        send_frame(w1, h1, -1, 0, 0);
        send_frame(w1, h1, -1, 0, 0);
        chk("rst_not_locked", locked, 0);
        send_frame(w1, h1, -1, 0, 0);
        chk("rst_relock", locked, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
